// File: rtl/addsub_pkg.sv
// Shared definitions for the nibble-serial add/subtract sequencer.
package addsub_pkg;

  // Width of the shared arithmetic slice.
  localparam int NIB_W = 4;

  // Controller state encoding.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Operation select values.
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Two's-complement overflow: operands agree in sign, result disagrees.
  function automatic logic ovf_calc(input logic a_msb, input logic beff_msb,
                                    input logic r_msb);
    return (a_msb == beff_msb) && (r_msb != a_msb);
  endfunction

endpackage

// File: rtl/addsub_nibble.sv
// Combinational 4-bit adder slice with carry in/out; operand inversion for
// subtract is applied by the caller.
module addsub_nibble (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic [4:0] sum_s;

  assign sum_s = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
  assign s     = sum_s[3:0];
  assign cout  = sum_s[4];

endmodule

// File: rtl/addsub_seq_ctrl.sv
// Nibble-serial add/subtract sequencer: one 4-bit slice is reused for each
// nibble, LSB first, with the carry chained through a register.
module addsub_seq_ctrl
  import addsub_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NIB   = WIDTH / NIB_W;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIB - 1);

  if (((WIDTH % NIB_W) != 0) || (WIDTH < NIB_W)) begin : g_bad_width
    $error("addsub_seq_ctrl: WIDTH must be a multiple of 4 and >= 4");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             op_q, op_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [IDX_W+1:0] base_s;
  logic [3:0]       sl_a_s;
  logic [3:0]       sl_b_s;
  logic [3:0]       sl_s;
  logic             sl_cout_s;

  // Bit offset of the nibble currently being processed.
  assign base_s = {idx_q, 2'b00};
  assign sl_a_s = a_q[base_s +: NIB_W];
  assign sl_b_s = (op_q == OP_ADD) ? b_q[base_s +: NIB_W] : ~b_q[base_s +: NIB_W];

  addsub_nibble u_nibble (
    .a    (sl_a_s),
    .b    (sl_b_s),
    .cin  (carry_q),
    .s    (sl_s),
    .cout (sl_cout_s)
  );

  // Next-state, datapath and flag computation for the sequencer.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          a_d      = a;
          b_d      = b;
          op_d     = op;
          idx_d    = '0;
          carry_d  = (op == OP_SUB);
          result_d = '0;
          state_d  = ST_RUN;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_RUN: begin
        result_d[base_s +: NIB_W] = sl_s;
        carry_d                   = sl_cout_s;
        if (idx_q == IDX_LAST) begin
          idx_d   = '0;
          cout_d  = sl_cout_s;
          ovf_d   = ovf_calc(a_q[WIDTH-1], b_q[WIDTH-1] ^ op_q, result_d[WIDTH-1]);
          zero_d  = (result_d == '0);
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= 1'b0;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign cout   = cout_q;
  assign ovf    = ovf_q;
  assign zero   = zero_q;

endmodule

// File: tb/tb_addsub_seq_ctrl.sv
// Directed testbench for addsub_seq_ctrl (WIDTH=16) with a result scoreboard.
module tb_addsub_seq_ctrl;

  typedef struct packed {
    logic [15:0] r;
    logic        c;
    logic        v;
    logic        z;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        op;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        cout;
  logic        ovf;
  logic        zero;

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];

  addsub_seq_ctrl #(.WIDTH(16)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout),
    .ovf    (ovf),
    .zero   (zero)
  );

  always #5 clk = ~clk;

  // Reference arithmetic on the full word.
  function automatic exp_t model(input logic o, input logic [15:0] x, input logic [15:0] y);
    exp_t        e;
    logic [15:0] be;
    logic [16:0] s;
    be  = y ^ {16{o}};
    s   = {1'b0, x} + {1'b0, be} + {16'd0, o};
    e.r = s[15:0];
    e.c = s[16];
    e.v = (x[15] == be[15]) && (s[15] != x[15]);
    e.z = (s[15:0] == 16'd0);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drive a one-cycle start pulse from the current negedge.
  task automatic issue(input logic o, input logic [15:0] x, input logic [15:0] y, input bit push);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    if (push) sb_q.push_back(model(o, x, y));
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    a     = 16'hDEAD;
    b     = 16'hBEEF;
    op    = ~o;
  endtask

  // Wait at negedges for done, counting cycles and busy cycles.
  task automatic wait_done(output int cyc, output int bc, output bit found);
    cyc   = 1;
    bc    = 0;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done === 1'b1) begin
        found = 1'b1;
        break;
      end
      if (busy === 1'b1) bc++;
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic check_top(input string tag);
    exp_t e;
    chk({tag, "_sb"}, 32'(sb_q.size() != 0), 32'd1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      chk({tag, "_result"}, 32'(result), 32'(e.r));
      chk({tag, "_cout"},   32'(cout),   32'(e.c));
      chk({tag, "_ovf"},    32'(ovf),    32'(e.v));
      chk({tag, "_zero"},   32'(zero),   32'(e.z));
      chk({tag, "_busy"},   32'(busy),   32'd0);
    end
  endtask

  task automatic run_normal(input string tag, input logic o, input logic [15:0] x, input logic [15:0] y);
    int cyc;
    int bc;
    bit found;
    @(negedge clk);
    issue(o, x, y, 1'b1);
    wait_done(cyc, bc, found);
    chk({tag, "_found"},   32'(found), 32'd1);
    chk({tag, "_latency"}, 32'(cyc),   32'd5);
    chk({tag, "_busycyc"}, 32'(bc),    32'd4);
    check_top(tag);
    @(negedge clk);
    chk({tag, "_pulse"},   32'(done),  32'd0);
  endtask

  initial begin
    int cyc;
    int bc;
    bit found;
    int dcnt;
    int bcnt;

    rst   = 1'b1;
    start = 1'b0;
    op    = 1'b0;
    a     = 16'h0000;
    b     = 16'h0000;
    repeat (3) @(negedge clk);
    chk("rst_busy",   32'(busy),   32'd0);
    chk("rst_done",   32'(done),   32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_flags",  32'({cout, ovf, zero}), 32'd0);
    rst = 1'b0;

    run_normal("add1",   1'b0, 16'h1234, 16'h4321);
    run_normal("sub1",   1'b1, 16'h000A, 16'h0005);
    run_normal("sub2",   1'b1, 16'h0000, 16'h0001);
    run_normal("addovf", 1'b0, 16'h7FFF, 16'h0001);

    // Wrap to zero, then a back-to-back start in the DONE cycle.
    @(negedge clk);
    issue(1'b0, 16'hFFFF, 16'h0001, 1'b1);
    wait_done(cyc, bc, found);
    chk("wrap_found",   32'(found), 32'd1);
    chk("wrap_latency", 32'(cyc),   32'd5);
    check_top("wrap");
    issue(1'b0, 16'h0001, 16'h0001, 1'b1);
    wait_done(cyc, bc, found);
    chk("b2b_found",   32'(found), 32'd1);
    chk("b2b_latency", 32'(cyc),   32'd5);
    chk("b2b_busycyc", 32'(bc),    32'd4);
    check_top("b2b");
    @(negedge clk);
    chk("b2b_pulse", 32'(done), 32'd0);

    // A start during RUN must be ignored and not queued.
    issue(1'b0, 16'h1111, 16'h1111, 1'b1);
    start = 1'b1;
    op    = 1'b1;
    a     = 16'hAAAA;
    b     = 16'h5555;
    @(negedge clk);
    start = 1'b0;
    wait_done(cyc, bc, found);
    chk("ign_found",   32'(found), 32'd1);
    chk("ign_latency", 32'(cyc),   32'd4);
    check_top("ign");
    dcnt = 0;
    bcnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done === 1'b1) dcnt++;
      if (busy === 1'b1) bcnt++;
    end
    chk("ign_extra_done", 32'(dcnt), 32'd0);
    chk("ign_extra_busy", 32'(bcnt), 32'd0);

    run_normal("subovf", 1'b1, 16'h8000, 16'h0001);

    // Reset during the second RUN cycle abandons the operation.
    issue(1'b0, 16'h0F0F, 16'h0101, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_busy",   32'(busy),   32'd0);
    chk("mid_done",   32'(done),   32'd0);
    chk("mid_result", 32'(result), 32'd0);
    chk("mid_flags",  32'({cout, ovf, zero}), 32'd0);
    rst  = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done === 1'b1) dcnt++;
    end
    chk("mid_no_done", 32'(dcnt), 32'd0);

    run_normal("fresh", 1'b0, 16'h0F0F, 16'h0101);

    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/addsub_seq_ctrl.md
Name: addsub_seq_ctrl

Overview:
Multi-cycle sequencer that performs WIDTH-bit add or subtract through a single shared 4-bit add/sub slice. It processes one nibble per clock, LSB first, and chains the carry between nibbles. It sits between a requester (start/op/operands) and the nibble datapath, and reports result, carry, signed overflow and zero with a start/busy/done handshake.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4 and >= 4 (elaboration error otherwise)
NIB, WIDTH/4, derived nibble count; not overridable

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
start  input  1  request; sampled only when busy=0
op  input  1  0 = add (a+b), 1 = subtract (a-b); sampled with start
a  input  WIDTH  operand A; sampled with start
b  input  WIDTH  operand B; sampled with start
busy  output  1  high while the FSM is in RUN
done  output  1  one-cycle pulse; result/flags valid from this cycle
result  output  WIDTH  sum/difference; held until next accepted start
cout  output  1  final carry out (subtract: 1 = no borrow)
ovf  output  1  two's-complement overflow
zero  output  1  result == 0

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset: state=IDLE; busy, done, result, cout, ovf, zero all 0; internal regs cleared. Reset mid-RUN abandons the operation with no done pulse.
- FSM states are IDLE, RUN and DONE.
  - IDLE: start=1 -> latch a, b, op; idx=0; carry=op; result cleared; go to RUN.
  - RUN: busy=1. The slice gets a[idx*4+:4], b[idx*4+:4] XOR {4{op}} and carry. The slice sum is written to result[idx*4+:4], its carry-out goes to carry, and idx increments. When idx==NIB-1: capture cout, ovf, zero and go to DONE.
  - DONE: done=1 for exactly this cycle, busy=0. start=1 here is accepted exactly as in IDLE (back-to-back, go to RUN). Otherwise go to IDLE.
- start while busy=1 is ignored; there is no queuing.
- Latency: with start sampled at edge k, the last nibble is written at edge k+NIB and done is high for the cycle after that edge. Throughput is one operation per NIB+1 cycles.
- Flag rules:
  - cout = carry out of the top nibble.
  - ovf = (a[MSB] == beff[MSB]) && (result[MSB] != a[MSB]), where beff = b XOR {WIDTH{op}}.
  - zero is computed on the complete result.
- Flags and result stay stable outside RUN. During RUN, result updates nibble by nibble and is not valid; cout/ovf/zero hold their previous values until the DONE transition.
- Operand changes after start are ignored, because operands are latched.
- Width rules:
  - idx is clog2(NIB) bits wide, minimum 1.
  - Arithmetic is modulo 2^WIDTH. No saturation.

Decomposition:
- Shared package addsub_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2
  - OP_ADD=1'b0, OP_SUB=1'b1
  - NIB_W=4
- One sub-module, addsub_nibble: purely combinational 4-bit slice.
  - Ports: a[3:0], b[3:0], cin, s[3:0], cout.
  - Operand inversion for subtract is done in the controller, not in the slice.
- The FSM, operand/result registers and flag logic live in addsub_seq_ctrl.

Test Plan (WIDTH=16):
- Add 0x1234+0x4321 -> done exactly 5 cycles after the start edge (4 RUN + DONE); result=0x5555, cout=0, ovf=0, zero=0; busy high for 4 cycles.
- Sub 0x000A-0x0005 -> result=0x0005, cout=1, ovf=0. Then sub 0x0000-0x0001 -> result=0xFFFF, cout=0 (borrow), ovf=0.
- Signed overflow:
  - sub 0x8000-0x0001 -> result=0x7FFF, ovf=1, cout=1
  - add 0x7FFF+0x0001 -> result=0x8000, ovf=1, cout=0
- Wrap and zero: add 0xFFFF+0x0001 -> result=0x0000, zero=1, cout=1, ovf=0. Then start asserted in the DONE cycle with 0x0001+0x0001 -> accepted, result=0x0002 after a further 5 cycles.
- Start with 0x1111+0x1111, then pulse start again with new operands during RUN -> second request ignored; result=0x2222, single done pulse.
- Start an add, assert rst on the 2nd RUN cycle -> next cycle state IDLE, busy=0, done never pulses, result=0, flags=0. A fresh start then completes normally.
